// File: rtl/dm_pkg.sv
// dm_pkg: shared types, error codes and helpers for the debug module system-bus access engine
package dm;
  typedef enum logic [2:0] {Idle, Read, Write, WaitRead, WaitWrite} sba_state_e;
  localparam logic [2:0] SbErrNone = 3'd0;
  localparam logic [2:0] SbErrBadAddr = 3'd2;
  localparam logic [2:0] SbErrAlign = 3'd3;
  localparam logic [2:0] SbErrSize = 3'd4;
  // size <= 3 only; 8'd1 << 8 wraps to 0 so the 8-byte case still yields 0xFF
  function automatic logic [7:0] sb_be(input logic [2:0] size, input logic [2:0] off);
    return ((8'd1 << (4'd1 << size)) - 8'd1) << off;
  endfunction
endpackage

// File: rtl/dm_sb_master.sv
// dm_sb_master: executes debugger SBCS/SBAddress/SBData accesses as single-beat bus transactions
// Ports: clk_i/rst_ni clock and async active-low reset; sbaddress_*/sbdata_*/sb* controls and
// trigger pulses from the CSR block; sbaddress_o/sbdata_o/sbdata_valid_o/sbbusy_o/sberror_* status
// back to it; master_* request/grant/response bus master port.
module dm_sb_master
  import dm::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  master_req_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i
);
  localparam int OffW = $clog2(BusWidth / 8);
  sba_state_e state_q, state_d;
  logic [BusWidth-1:0] addr_q, addr_d, addr_nx, data_q, data_d;
  logic dv_q, dv_d, ev_q, ev_d;
  logic [2:0] err_q, err_d, off, amask;
  logic [BusWidth/8-1:0] be;
  logic go_wr, go_rd, size_bad, misalign;
  // checks see the address the access will actually use, including one loaded this cycle
  assign addr_nx = sbaddress_write_valid_i ? sbaddress_i : addr_q;
  assign go_wr = sbdata_write_valid_i;
  assign go_rd = (sbaddress_write_valid_i && sbreadonaddr_i) || (sbdata_read_valid_i && sbreadondata_i);
  assign size_bad = sbaccess_i > 3'(OffW);
  assign amask = 3'((4'd1 << sbaccess_i) - 4'd1);
  assign misalign = |(3'(addr_nx[OffW-1:0]) & amask);
  assign off = 3'(addr_q[OffW-1:0]);
  assign be = (BusWidth/8)'(sb_be(sbaccess_i, off));
  assign master_req_o = (state_q == Read) || (state_q == Write);
  assign master_we_o = state_q == Write;
  assign master_add_o = {addr_q[BusWidth-1:OffW], {OffW{1'b0}}};
  assign master_be_o = master_req_o ? be : '0;
  assign master_wdata_o = master_req_o ? sbdata_i << {off, 3'b000} : '0;
  assign sbbusy_o = state_q != Idle;
  assign sbaddress_o = addr_q;
  assign sbdata_o = data_q;
  assign sbdata_valid_o = dv_q;
  assign sberror_valid_o = ev_q;
  assign sberror_o = err_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_nx;
    data_d = data_q;
    dv_d = 1'b0;
    ev_d = 1'b0;
    err_d = err_q;
    unique case (state_q)
      Idle: begin
        if (go_wr || go_rd) begin
          if (size_bad) begin
            ev_d = 1'b1;
            err_d = SbErrSize;
          end else if (misalign) begin
            ev_d = 1'b1;
            err_d = SbErrAlign;
          end else begin
            state_d = go_wr ? Write : Read;
          end
        end
      end
      Read: state_d = master_gnt_i ? WaitRead : Read;
      Write: state_d = master_gnt_i ? WaitWrite : Write;
      WaitRead, WaitWrite: begin
        if (master_r_valid_i) begin
          state_d = Idle;
          if (master_r_err_i) begin
            ev_d = 1'b1;
            err_d = SbErrBadAddr;
          end else begin
            if (state_q == WaitRead) begin
              data_d = master_r_rdata_i >> {off, 3'b000};
              dv_d = 1'b1;
            end
            if (sbautoincrement_i) addr_d = addr_q + (BusWidth'(1) << sbaccess_i);
          end
        end
      end
      default: state_d = Idle;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Idle;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
      ev_q <= 1'b0;
      err_q <= SbErrNone;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      dv_q <= dv_d;
      ev_q <= ev_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/dm_sb_master.md
# dm_sb_master

System-bus access engine of the debug module. It executes the SBCS/SBAddress/SBData accesses requested by the debugger as single-beat transactions on a request/grant/response bus master port. It sits downstream of the DM CSR block, which decodes DMI writes and reads into the trigger pulses below. Read data, busy and error status flow back to that block.

## Interface
- BusWidth, 32: bus address/data width; only 32 and 64 are legal.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- sbaddress_i  in  BusWidth  address value written by the debugger.
- sbaddress_write_valid_i  in  1  one-cycle pulse; SBAddress0 written this cycle.
- sbreadonaddr_i  in  1  SBCS.sbreadonaddr.
- sbautoincrement_i  in  1  SBCS.sbautoincrement.
- sbaccess_i  in  3  SBCS.sbaccess, log2 of access size in bytes.
- sbreadondata_i  in  1  SBCS.sbreadondata.
- sbdata_i  in  BusWidth  write data.
- sbdata_read_valid_i  in  1  one-cycle pulse; SBData0 read this cycle.
- sbdata_write_valid_i  in  1  one-cycle pulse; SBData0 written this cycle.
- sbaddress_o  out  BusWidth  current (auto-incremented) address.
- sbdata_o  out  BusWidth  read data, right-aligned.
- sbdata_valid_o  out  1  one-cycle pulse; sbdata_o updated.
- sbbusy_o  out  1  access in progress.
- sberror_valid_o  out  1  one-cycle pulse; sberror_o valid.
- sberror_o  out  3  error code.
- master_req_o, master_we_o  out  1  bus request / write enable.
- master_add_o, master_wdata_o  out  BusWidth  address / lane-aligned write data.
- master_be_o  out  BusWidth/8  byte enables.
- master_gnt_i, master_r_valid_i, master_r_err_i  in  1  grant / response valid / response error.
- master_r_rdata_i  in  BusWidth  response data.

## Operation
- The address register loads sbaddress_i on sbaddress_write_valid_i, including while busy.
- The FSM states are Idle, Read, Write, WaitRead and WaitWrite.
- Idle transitions, evaluated in this priority order:
  - sbdata_write_valid_i goes to Write.
  - sbaddress_write_valid_i with sbreadonaddr_i goes to Read. The read uses the newly loaded sbaddress_i.
  - sbdata_read_valid_i with sbreadondata_i goes to Read.
- Triggers arriving outside Idle are ignored; sbbusyerror is handled in the CSR block.
- Pre-checks run on entry, in place of Read or Write. If either check fails, the FSM stays in Idle, issues no bus request and raises an error:
  - Unsupported size raises sberror 4: sbaccess_i > 2 when BusWidth = 32, or sbaccess_i > 3 when BusWidth = 64.
  - Misaligned address raises sberror 3: address[sbaccess-1:0] != 0.
- Read and Write states:
  - master_req_o is held high, with address and controls stable, until master_gnt_i.
  - On grant, the FSM moves to WaitRead or WaitWrite.
- WaitRead and WaitWrite states:
  - On master_r_valid_i without master_r_err_i: for reads, sbdata_o = master_r_rdata_i >> (8 × address[log2(BusWidth/8)-1:0]) and sbdata_valid_o pulses. Then, if sbautoincrement_i is set, address += 1 << sbaccess_i (wraps modulo 2^BusWidth). Then return to Idle.
  - On master_r_valid_i with master_r_err_i: sberror 2 is raised; sbdata_o and the address are unchanged; return to Idle.
- master_add_o is the address with its low log2(BusWidth/8) bits cleared.
- master_be_o = ((1 << (1 << sbaccess)) − 1) << byte offset.
- master_wdata_o = sbdata_i << (8 × byte offset).

## Timing
- Reset values:
  - State is Idle.
  - sbaddress_o, sbdata_o and sberror_o are 0.
  - All other outputs are 0.
- Trigger in cycle N:
  - master_req_o goes high in cycle N+1.
  - A check-failure error pulse appears in cycle N+1 instead.
- Grant in cycle M: master_req_o is low in M+1, i.e. single outstanding transaction.
- r_valid in cycle K:
  - sbdata_o, sbdata_valid_o, the error pulse and the incremented address are visible in K+1.
  - sbbusy_o falls in K+1.
- sbbusy_o = (state != Idle), registered. A new trigger is accepted in the first Idle cycle.
- sberror_o holds its last value until the next error.
- Same-cycle grant and r_valid is illegal on the bus; this is not required to be handled.
- Reset asserted mid-access aborts immediately; the bus side must also be reset.

## Structure
- Add to package dm:
  - `sba_state_e`.
  - sberror constants: SbErrNone = 0, SbErrBadAddr = 2, SbErrAlign = 3, SbErrSize = 4.
  - A function computing byte enables from size and offset.
- No sub-module; a single module of roughly 200 lines.

## Test plan
- BusWidth 32, address 0x1000, data 0xDEADBEEF, sbaccess 2, data write, gnt after 2 cycles, then r_valid → one request with be 0xF and wdata 0xDEADBEEF; busy for 5 cycles.
- Read-on-address 0x1003, sbaccess 0, rdata 0xAB000000 → be 0x8, add 0x1000, sbdata_o 0xAB, sbdata_valid_o pulses once.
- Autoincrement with sbaccess 1 from 0xFFFFFFFE, read-on-data twice → second access at 0x00000000 (wrap-around).
- sbaccess 3 on BusWidth 32, or address 0x1002 with sbaccess 2 → no master_req_o, error codes 4 and 3 respectively, one-cycle pulse.
- r_err on read → sberror 2; sbdata_o and address are unchanged.
- Data write and read-on-address in the same cycle → write performed; a trigger while busy is ignored.
